// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the alarm controller.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_t;

  typedef logic [3:0] bcd_t;

  localparam int RING_SECS_DEF   = 60;
  localparam int SNOOZE_SECS_DEF = 300;
  localparam int MAX_SNOOZE_DEF  = 3;

endpackage

// File: rtl/alarm_ctrl_push_edge.sv
// Two-flop synchronizer for an active-low pushbutton, emitting a one-clk pulse
// on each synchronized press (1 -> 0 transition).
module push_edge (
  input  logic clk,
  input  logic reset,
  input  logic push,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes a synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= push;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: triggers on the rising edge of a time/alarm match,
// rings with a gated beep, supports limited snoozes and stop.
module alarm_ctrl
  import clock_pkg::*;
#(
  parameter int RING_SECS   = RING_SECS_DEF,
  parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
  parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [3:0] t_h1,
  input  logic [3:0] t_h0,
  input  logic [3:0] t_m1,
  input  logic [3:0] t_m0,
  input  logic [3:0] s2h1,
  input  logic [3:0] s2h0,
  input  logic [3:0] s2m1,
  input  logic [3:0] s2m0,
  input  logic       switch,
  input  logic       push_snooze,
  input  logic       push_stop,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);

  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]       SNOOZE_LIM  = 2'(MAX_SNOOZE);

  alarm_state_t     state_q, state_d;
  logic [CNT_W-1:0] sec_q, sec_d;
  logic [1:0]       snz_q, snz_d;
  logic             beep_q, beep_d;
  logic             match, match_q, trigger;
  logic             snooze_press, stop_press;

  push_edge u_snooze (.clk(clk), .reset(reset), .push(push_snooze), .press(snooze_press));
  push_edge u_stop   (.clk(clk), .reset(reset), .push(push_stop),   .press(stop_press));

  assign match   = (t_h1 == s2h1) && (t_h0 == s2h0) && (t_m1 == s2m1) && (t_m0 == s2m0);
  assign trigger = match & ~match_q & switch;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    snz_d   = snz_q;
    beep_d  = beep_q;
    if (!switch) begin
      state_d = ST_IDLE;
      sec_d   = '0;
      snz_d   = '0;
      beep_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_d = ST_RINGING;
            sec_d   = '0;
            snz_d   = '0;
            beep_d  = 1'b0;
          end
        end
        ST_RINGING: begin
          if (stop_press) begin
            state_d = ST_IDLE;
            sec_d   = '0;
            snz_d   = '0;
          end else if (snooze_press && (snz_q < SNOOZE_LIM)) begin
            state_d = ST_SNOOZE;
            sec_d   = '0;
            snz_d   = snz_q + 2'd1;
          end else if (tick_1hz) begin
            beep_d = ~beep_q;
            if (sec_q == RING_LAST) begin
              state_d = ST_IDLE;
              sec_d   = '0;
            end else begin
              sec_d = sec_q + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_press) begin
            state_d = ST_IDLE;
            sec_d   = '0;
            snz_d   = '0;
          end else if (tick_1hz) begin
            if (sec_q == SNOOZE_LAST) begin
              state_d = ST_RINGING;
              sec_d   = '0;
              beep_d  = 1'b0;
            end else begin
              sec_d = sec_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          sec_d   = '0;
          snz_d   = '0;
          beep_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      snz_q   <= '0;
      beep_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
      beep_q  <= beep_d;
      match_q <= match;
    end
  end

  // Outputs decode registered state only, so they change one clk after the cause.
  assign ringing    = (state_q == ST_RINGING);
  assign snoozing   = (state_q == ST_SNOOZE);
  assign buzzer     = ringing & ~beep_q;
  assign snooze_cnt = snz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with the default timing parameters.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [3:0] t_h1, t_h0, t_m1, t_m0;
  logic [3:0] s2h1, s2h0, s2m1, s2m0;
  logic       switch;
  logic       push_snooze, push_stop;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alarm_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .t_h1(t_h1), .t_h0(t_h0), .t_m1(t_m1), .t_m0(t_m0),
    .s2h1(s2h1), .s2h0(s2h0), .s2m1(s2m1), .s2m0(s2m0),
    .switch(switch), .push_snooze(push_snooze), .push_stop(push_stop),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic snz, input logic stp);
    push_snooze = ~snz;
    push_stop   = ~stp;
    step(1);
    push_snooze = 1'b1;
    push_stop   = 1'b1;
    step(4);
  endtask

  // Leave 07:30, then return to it so match shows a fresh rising edge.
  task automatic retrigger();
    t_m0 = 4'd1;
    step(2);
    t_m0 = 4'd0;
    step(1);
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; switch = 1'b1;
    push_snooze = 1'b1; push_stop = 1'b1;
    s2h1 = 4'd0; s2h0 = 4'd7; s2m1 = 4'd3; s2m0 = 4'd0;
    t_h1 = 4'd0; t_h0 = 4'd7; t_m1 = 4'd2; t_m0 = 4'd9;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst_ringing",  {3'b0, ringing},  4'd0);
    chk("rst_snoozing", {3'b0, snoozing}, 4'd0);
    chk("rst_buzzer",   {3'b0, buzzer},   4'd0);
    chk("rst_cnt",      {2'b0, snooze_cnt}, 4'd0);

    // 07:29 -> 07:30 triggers on the next clk
    t_m1 = 4'd3; t_m0 = 4'd0;
    step(1);
    chk("trig_ringing", {3'b0, ringing}, 4'd1);
    chk("trig_buzzer",  {3'b0, buzzer},  4'd1);
    chk("trig_cnt",     {2'b0, snooze_cnt}, 4'd0);

    tick();
    chk("beep_off_tick1", {3'b0, buzzer}, 4'd0);
    ticks(58);
    chk("ring_tick59", {3'b0, ringing}, 4'd1);
    tick();
    chk("autostop_ringing", {3'b0, ringing}, 4'd0);
    chk("autostop_buzzer",  {3'b0, buzzer},  4'd0);
    step(10);
    chk("no_retrigger", {3'b0, ringing}, 4'd0);

    // snooze cycle up to the limit
    retrigger();
    chk("ring2", {3'b0, ringing}, 4'd1);
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0);
      chk("snz_state", {3'b0, snoozing}, 4'd1);
      chk("snz_cnt",   {2'b0, snooze_cnt}, 4'(k));
      ticks(299);
      chk("snz_tick299", {3'b0, snoozing}, 4'd1);
      tick();
      chk("rering",        {3'b0, ringing}, 4'd1);
      chk("rering_buzzer", {3'b0, buzzer},  4'd1);
    end
    press(1'b1, 1'b0);
    chk("snz4_ignored_ring", {3'b0, ringing}, 4'd1);
    chk("snz4_ignored_cnt",  {2'b0, snooze_cnt}, 4'd3);
    press(1'b0, 1'b1);
    chk("stop_ringing", {3'b0, ringing}, 4'd0);
    chk("stop_cnt",     {2'b0, snooze_cnt}, 4'd0);

    // stop and snooze together: stop wins
    retrigger();
    chk("ring3", {3'b0, ringing}, 4'd1);
    press(1'b1, 1'b1);
    chk("both_ringing",  {3'b0, ringing},  4'd0);
    chk("both_snoozing", {3'b0, snoozing}, 4'd0);
    chk("both_cnt",      {2'b0, snooze_cnt}, 4'd0);

    // disarm while snoozing
    retrigger();
    press(1'b1, 1'b0);
    chk("pre_disarm_snz", {3'b0, snoozing}, 4'd1);
    switch = 1'b0;
    step(1);
    chk("disarm_snoozing", {3'b0, snoozing}, 4'd0);
    chk("disarm_cnt",      {2'b0, snooze_cnt}, 4'd0);
    retrigger();
    step(2);
    chk("disarmed_match", {3'b0, ringing}, 4'd0);
    switch = 1'b1;
    step(3);
    chk("arm_late_no_ring", {3'b0, ringing}, 4'd0);

    // reset mid-ring, then release with match still present
    retrigger();
    chk("ring4", {3'b0, ringing}, 4'd1);
    reset = 1'b1;
    step(1);
    chk("rstmid_ringing", {3'b0, ringing}, 4'd0);
    chk("rstmid_buzzer",  {3'b0, buzzer},  4'd0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("post_rst_trigger", {3'b0, ringing}, 4'd1);

    // sub-cycle glitch on snooze straddling one edge
    #7 push_snooze = 1'b0;
    #4 push_snooze = 1'b1;
    @(posedge clk);
    #1;
    step(5);
    chk("glitch_snoozing", {3'b0, snoozing}, 4'd1);
    chk("glitch_cnt",      {2'b0, snooze_cnt}, 4'd1);
    press(1'b0, 1'b1);
    chk("stop_snz_state", {3'b0, snoozing}, 4'd0);
    chk("stop_snz_cnt",   {2'b0, snooze_cnt}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SECS, default 60, ring duration in 1 Hz ticks before auto-stop.
REQ-002 Parameter SNOOZE_SECS, default 300, snooze duration in 1 Hz ticks before re-ring.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick_1hz  in  1  one-clk-wide pulse, once per second, synchronous to clk.
REQ-007 t_h1, t_h0, t_m1, t_m0  in  4 each  current time, BCD digits, 00:00–23:59.
REQ-008 s2h1, s2h0, s2m1, s2m0  in  4 each  alarm time from the alarm-set stage, BCD.
REQ-009 switch  in  1  alarm enable; 1 = armed.
REQ-010 push_snooze  in  1  active-low pushbutton, asynchronous.
REQ-011 push_stop  in  1  active-low pushbutton, asynchronous.
REQ-012 buzzer  out  1  audible drive, gated beep pattern.
REQ-013 ringing  out  1  high in RINGING state.
REQ-014 snoozing  out  1  high in SNOOZE state.
REQ-015 snooze_cnt  out  2  snoozes consumed in current alarm event.

Function
REQ-016 Each push input SHALL pass a 2-flop synchronizer; a press event = one-clk pulse on synchronized 1->0 transition.
REQ-017 match = all four time digits equal all four alarm digits, combinational; match_q = match registered.
REQ-018 Trigger SHALL be match & ~match_q & switch (rising edge of match only; no re-trigger within the same minute).
REQ-019 States: IDLE, RINGING, SNOOZE.
REQ-020 IDLE -> RINGING on trigger; sec_cnt cleared, snooze_cnt cleared.
REQ-021 RINGING: sec_cnt increments on tick_1hz; at sec_cnt == RING_SECS-1 with tick -> IDLE.
REQ-022 RINGING: stop press -> IDLE, snooze_cnt cleared.
REQ-023 RINGING: snooze press with snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt+1, sec_cnt cleared; with snooze_cnt == MAX_SNOOZE press ignored.
REQ-024 SNOOZE: sec_cnt increments on tick; at SNOOZE_SECS-1 with tick -> RINGING, sec_cnt cleared.
REQ-025 SNOOZE: stop press -> IDLE, snooze_cnt cleared.
REQ-026 Stop and snooze press in same cycle: stop wins.
REQ-027 switch == 0 in any state: next cycle IDLE, counters cleared; overrides all other events.
REQ-028 Trigger while RINGING/SNOOZE ignored.
REQ-029 beep bit toggles on every tick in RINGING, cleared on RINGING entry; buzzer = ringing & ~beep (starts sounding in first cycle of RINGING).
REQ-030 sec_cnt width = clog2(max(RING_SECS, SNOOZE_SECS)); never exceeds its terminal value.
REQ-031 Outputs registered; state changes visible one clk after causing event.

Reset
REQ-032 On reset: state IDLE, buzzer 0, ringing 0, snoozing 0, snooze_cnt 0, sec_cnt 0, beep 0, match_q 0, synchronizers 1 (released).
REQ-033 Reset mid-RINGING/SNOOZE SHALL silence buzzer next clk; a match held through reset release SHALL trigger only if match_q sees 0->1 afterwards (match_q reset 0 implies trigger one cycle after release if still matching and armed).

Structure
REQ-034 Shared package clock_pkg: alarm_state_t enum, bcd_t (4-bit) typedef, default RING_SECS/SNOOZE_SECS/MAX_SNOOZE constants.
REQ-035 One sub-module push_edge: 2-flop sync + falling-edge pulse, instantiated twice.

Verification
REQ-036 Alarm 07:30, switch=1, time steps 07:29->07:30 -> ringing=1 next clk, buzzer=1, snooze_cnt=0.
REQ-037 Ringing, no buttons, 60 ticks -> IDLE after 60th tick, buzzer=0; time stays 07:30 -> no re-trigger.
REQ-038 Ringing, snooze press -> snoozing=1, snooze_cnt=1; 300 ticks -> ringing=1; repeat to snooze_cnt=3, 4th press ignored, ringing stays 1.
REQ-039 Ringing, stop and snooze pressed same clk -> IDLE, snooze_cnt=0.
REQ-040 Snoozing, switch->0 -> IDLE next clk; switch=0 at 07:30 match -> no ringing.
REQ-041 Reset asserted mid-ringing -> all outputs 0 next clk; push glitch shorter than 1 clk across sync -> at most one press event.
